// File: rtl/volatility_engine.sv
// rtl/volatility_engine.sv - per-stock windowed mid-price variance engine
// Circular buffer plus running sum/sumsq per stock; five-state pipeline FSM per update.
module volatility_engine #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_STOCKS   = 4,
  parameter int MAX_WINDOW   = 32,
  parameter int FP_WORD_SIZE = 64,
  parameter int FRAC_BITS    = 32
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic                            i_data_valid,
  output logic                            o_ready,
  input  logic [$clog2(NUM_STOCKS)-1:0]   i_stock_id,
  input  logic [DATA_WIDTH-1:0]           i_best_ask,
  input  logic [DATA_WIDTH-1:0]           i_best_bid,
  input  logic                            i_cfg_valid,
  input  logic [$clog2(NUM_STOCKS)-1:0]   i_cfg_stock,
  input  logic [$clog2(MAX_WINDOW):0]     i_cfg_window,
  input  logic [FP_WORD_SIZE-1:0]         i_cfg_recip,
  input  logic                            i_flush,
  output logic                            o_data_valid,
  output logic [$clog2(NUM_STOCKS)-1:0]   o_stock_id,
  output logic [DATA_WIDTH-1:0]           o_curr_price,
  output logic [FP_WORD_SIZE-1:0]         o_volatility,
  output logic                            o_window_full,
  output logic                            o_saturated
);
  localparam int SW   = $clog2(NUM_STOCKS);
  localparam int PW   = $clog2(MAX_WINDOW);
  localparam int WW   = PW + 1;
  localparam int SUMW = DATA_WIDTH + PW;
  localparam int SQW  = 2 * DATA_WIDTH + PW;
  localparam int MW   = SUMW + FP_WORD_SIZE;
  localparam int EW   = SQW + FP_WORD_SIZE;
  localparam int VW   = 2 * MW;

  typedef enum logic [2:0] {ST_IDLE, ST_RD, ST_ACC, ST_MUL, ST_VAR} state_t;
  state_t state;

  logic [WW-1:0]           cnt   [NUM_STOCKS];
  logic [PW-1:0]           wptr  [NUM_STOCKS];
  logic [SUMW-1:0]         sum   [NUM_STOCKS];
  logic [SQW-1:0]          sumsq [NUM_STOCKS];
  logic [WW-1:0]           win   [NUM_STOCKS];
  logic [FP_WORD_SIZE-1:0] recip [NUM_STOCKS];
  logic [DATA_WIDTH-1:0]   buf_mem [NUM_STOCKS][MAX_WINDOW];

  logic [SW-1:0]         r_stock;
  logic [DATA_WIDTH-1:0] r_mid;
  logic [DATA_WIDTH-1:0] r_old;
  logic [SUMW-1:0]       r_sum;
  logic [SQW-1:0]        r_sumsq;
  logic                  r_full;
  logic [MW-1:0]         r_mean;
  logic [EW-1:0]         r_ex2;

  logic                    pend_valid;
  logic                    pend_cfg;
  logic [SW-1:0]           pend_stock;
  logic [WW-1:0]           pend_window;
  logic [FP_WORD_SIZE-1:0] pend_recip;

  logic req_cfg;
  logic req_any;
  assign req_cfg = i_cfg_valid && (i_cfg_window != '0) && (i_cfg_window <= WW'(MAX_WINDOW));
  assign req_any = req_cfg || i_flush;

  logic [DATA_WIDTH-1:0] mid_in;
  assign mid_in = DATA_WIDTH'(({1'b0, i_best_ask} + {1'b0, i_best_bid}) >> 1);

  // Running-sum update for the ACC stage; evicts the oldest entry once the window is full
  logic [2*DATA_WIDTH-1:0] mid_sq, old_sq;
  logic [SUMW-1:0]         sum_n;
  logic [SQW-1:0]          sq_n;
  logic [WW-1:0]           cnt_n;
  logic [PW-1:0]           wptr_n;
  logic                    full_n;

  always_comb begin
    mid_sq = (2*DATA_WIDTH)'(r_mid) * (2*DATA_WIDTH)'(r_mid);
    old_sq = (2*DATA_WIDTH)'(r_old) * (2*DATA_WIDTH)'(r_old);
    if (cnt[r_stock] == win[r_stock]) begin
      sum_n = sum[r_stock] + SUMW'(r_mid) - SUMW'(r_old);
      sq_n  = sumsq[r_stock] + SQW'(mid_sq) - SQW'(old_sq);
      cnt_n = cnt[r_stock];
    end else begin
      sum_n = sum[r_stock] + SUMW'(r_mid);
      sq_n  = sumsq[r_stock] + SQW'(mid_sq);
      cnt_n = cnt[r_stock] + WW'(1);
    end
    wptr_n = ({1'b0, wptr[r_stock]} == win[r_stock] - WW'(1)) ? '0 : wptr[r_stock] + PW'(1);
    full_n = (cnt_n == win[r_stock]);
  end

  // Rounding in the reciprocal can push E[x^2] - mean^2 slightly negative
  logic [VW-1:0]           msq, ex2_ext, diff;
  logic                    var_sat;
  logic [FP_WORD_SIZE-1:0] var_val;

  always_comb begin
    msq     = (VW'(r_mean) * VW'(r_mean)) >> FRAC_BITS;
    ex2_ext = VW'(r_ex2);
    diff    = (ex2_ext < msq) ? '0 : ex2_ext - msq;
    var_sat = |diff[VW-1:FP_WORD_SIZE];
    var_val = var_sat ? '1 : diff[FP_WORD_SIZE-1:0];
  end

  always_ff @(posedge i_clk) begin
    if (state == ST_RD)  r_old <= buf_mem[r_stock][wptr[r_stock]];
    if (state == ST_ACC) buf_mem[r_stock][wptr[r_stock]] <= r_mid;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= ST_IDLE;
      o_ready       <= 1'b1;
      o_data_valid  <= 1'b0;
      o_stock_id    <= '0;
      o_curr_price  <= '0;
      o_volatility  <= '0;
      o_window_full <= 1'b0;
      o_saturated   <= 1'b0;
      r_stock       <= '0;
      r_mid         <= '0;
      r_sum         <= '0;
      r_sumsq       <= '0;
      r_full        <= 1'b0;
      r_mean        <= '0;
      r_ex2         <= '0;
      pend_valid    <= 1'b0;
      pend_cfg      <= 1'b0;
      pend_stock    <= '0;
      pend_window   <= '0;
      pend_recip    <= '0;
      for (int i = 0; i < NUM_STOCKS; i++) begin
        cnt[i]   <= '0;
        wptr[i]  <= '0;
        sum[i]   <= '0;
        sumsq[i] <= '0;
        win[i]   <= WW'(MAX_WINDOW);
        recip[i] <= '0;
      end
    end else begin
      o_data_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_data_valid) begin
            r_stock <= i_stock_id;
            r_mid   <= mid_in;
            o_ready <= 1'b0;
            state   <= ST_RD;
          end
        end
        ST_RD: state <= ST_ACC;
        ST_ACC: begin
          sum[r_stock]   <= sum_n;
          sumsq[r_stock] <= sq_n;
          cnt[r_stock]   <= cnt_n;
          wptr[r_stock]  <= wptr_n;
          r_sum          <= sum_n;
          r_sumsq        <= sq_n;
          r_full         <= full_n;
          state          <= ST_MUL;
        end
        ST_MUL: begin
          r_mean <= MW'(r_sum) * MW'(recip[r_stock]);
          r_ex2  <= EW'(r_sumsq) * EW'(recip[r_stock]);
          state  <= ST_VAR;
        end
        ST_VAR: begin
          o_data_valid  <= 1'b1;
          o_stock_id    <= r_stock;
          o_curr_price  <= r_mid;
          o_volatility  <= r_full ? var_val : '0;
          o_window_full <= r_full;
          o_saturated   <= r_full && var_sat;
          o_ready       <= 1'b1;
          state         <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      // Pending clear lands on the edge back to IDLE; a same-cycle request is applied after it
      if (state == ST_VAR && pend_valid) begin
        pend_valid        <= 1'b0;
        cnt[pend_stock]   <= '0;
        wptr[pend_stock]  <= '0;
        sum[pend_stock]   <= '0;
        sumsq[pend_stock] <= '0;
        if (pend_cfg) begin
          win[pend_stock]   <= pend_window;
          recip[pend_stock] <= pend_recip;
        end
      end
      if (req_any) begin
        if (state == ST_IDLE || state == ST_VAR) begin
          cnt[i_cfg_stock]   <= '0;
          wptr[i_cfg_stock]  <= '0;
          sum[i_cfg_stock]   <= '0;
          sumsq[i_cfg_stock] <= '0;
          if (req_cfg) begin
            win[i_cfg_stock]   <= i_cfg_window;
            recip[i_cfg_stock] <= i_cfg_recip;
          end
        end else begin
          pend_valid  <= 1'b1;
          pend_cfg    <= req_cfg;
          pend_stock  <= i_cfg_stock;
          pend_window <= i_cfg_window;
          pend_recip  <= i_cfg_recip;
        end
      end
    end
  end
endmodule
